// File: rtl/subtract_stream_core.sv
// Streaming |base - img| background subtraction with threshold/mode and frame start/done; optional SUBTRACT_FG_COUNT_EN adds fg_count.
// Latency: a paired pop in cycle N gives out_wr_en in cycle N+2 at the earliest; 1 pixel/cycle sustained.
// Backpressure: out_full stalls stage 2, then stage 1, then the paired input pops; nothing is dropped.
module subtract_stream_core #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [1:0]            mode,
  output logic                  done,
  output logic                  busy,
  input  logic                  in_empty_base,
  output logic                  in_rd_en_base,
  input  logic [DATA_WIDTH-1:0] in_dout_base,
  input  logic                  in_empty_img,
  output logic                  in_rd_en_img,
  input  logic [DATA_WIDTH-1:0] in_dout_img,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] out_din
`ifdef SUBTRACT_FG_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  fg_count
`endif
);

  localparam int TOTAL_PIX = WIDTH * HEIGHT;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TOTAL_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  pix_cnt;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [1:0]            mode_q;

  logic                  s1_vld, s2_vld;
  logic [DATA_WIDTH-1:0] s1_dat, s2_dat;
  logic                  s1_adv, s2_adv;
  logic                  pop;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fg;
  logic [DATA_WIDTH-1:0] s2_next;

  assign s2_adv = !s2_vld || !out_full;
  assign s1_adv = !s1_vld || s2_adv;
  // The FSM leaves RUN on the final pop, so no pop can exceed the frame size.
  assign pop    = (state == S_RUN) && !in_empty_base && !in_empty_img && s1_adv;

  assign in_rd_en_base = pop;
  assign in_rd_en_img  = pop;
  assign out_wr_en     = s2_vld && !out_full;
  assign out_din       = s2_dat;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

  assign diff = (in_dout_base >= in_dout_img) ? (in_dout_base - in_dout_img)
                                              : (in_dout_img - in_dout_base);

  always_comb begin
    fg = (s1_dat > thr_q);
    case (mode_q)
      2'd1:    s2_next = s1_dat;
      2'd2:    s2_next = fg ? s1_dat : '0;
      default: s2_next = fg ? '1 : '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
      thr_q   <= '0;
      mode_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_RUN;
          thr_q   <= threshold;
          mode_q  <= mode;
          pix_cnt <= '0;
        end
        S_RUN: if (pop) begin
          pix_cnt <= pix_cnt + CNT_WIDTH'(1);
          if (pix_cnt == LAST_CNT) state <= S_DRAIN;
        end
        S_DRAIN: if (!s1_vld && !s2_vld) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= pop;
        if (pop) s1_dat <= diff;
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_dat <= s2_next;
      end
    end
  end

`ifdef SUBTRACT_FG_COUNT_EN
  logic s2_fg;

  // Foreground is counted when the pixel actually leaves, so stalls never double count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_fg    <= 1'b0;
      fg_count <= '0;
    end else begin
      if (s2_adv && s1_vld) s2_fg <= fg;
      if (state == S_IDLE && start)
        fg_count <= '0;
      else if (out_wr_en && s2_fg)
        fg_count <= fg_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_subtract_stream_core.sv
// Randomised bench for subtract_stream_core on a small 8x4 frame against a per-pixel reference model.
module tb_subtract_stream_core;
  localparam int DW = 8, W = 8, H = 4, CW = 6, TOTAL = W * H;

  logic clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic [1:0] mode = '0;
  logic done, busy, in_rd_en_base, in_rd_en_img, out_wr_en;
  logic in_empty_base = 1'b0, in_empty_img = 1'b0, out_full = 1'b0;
  logic [DW-1:0] in_dout_base = '0, in_dout_img = '0, out_din;
`ifdef SUBTRACT_FG_COUNT_EN
  logic [CW-1:0] fg_count;
`endif

  always #5 clock = ~clock;

  subtract_stream_core #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .threshold(threshold), .mode(mode),
    .done(done), .busy(busy),
    .in_empty_base(in_empty_base), .in_rd_en_base(in_rd_en_base), .in_dout_base(in_dout_base),
    .in_empty_img(in_empty_img), .in_rd_en_img(in_rd_en_img), .in_dout_img(in_dout_img),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din)
`ifdef SUBTRACT_FG_COUNT_EN
    , .fg_count(fg_count)
`endif
  );

  logic [DW-1:0] base_q[$], img_q[$], got_q[$], exp_q[$];
  int exp_fg, checks = 0, failures = 0;
  int cyc_cnt = 0, pops, done_cnt, proto_err, busy_err;
  int first_pop, last_pop, first_wr, last_wr;
  int full_mode = 0;
  bit img_gate = 1'b0, prev_done = 1'b0;

  task automatic set_inputs();
    in_empty_base = (base_q.size() == 0);
    in_dout_base  = (base_q.size() == 0) ? '0 : base_q[0];
    in_empty_img  = (img_q.size() == 0) || (img_gate && $urandom_range(0, 2) == 0);
    in_dout_img   = (img_q.size() == 0) ? '0 : img_q[0];
    case (full_mode)
      1:       out_full = (cyc_cnt % 3 == 0);
      2:       out_full = ($urandom_range(0, 1) == 1);
      default: out_full = 1'b0;
    endcase
  endtask

  // One clock: sample decisions at negedge, apply FIFO effects just after posedge.
  task automatic cyc();
    logic rb, ri, wr, eb, ei, fl, dn, bs;
    logic [DW-1:0] d;
    @(negedge clock);
    rb = in_rd_en_base; ri = in_rd_en_img; wr = out_wr_en; d = out_din;
    dn = done; bs = busy; eb = in_empty_base; ei = in_empty_img; fl = out_full;
    if (rb !== ri) proto_err++;
    if (rb === 1'b1 && (eb || ei)) proto_err++;
    if (wr === 1'b1 && fl) proto_err++;
    if (prev_done && bs !== 1'b0) busy_err++;
    prev_done = (dn === 1'b1);
    @(posedge clock);
    #1;
    cyc_cnt++;
    if (rb === 1'b1 && ri === 1'b1) begin
      if (base_q.size() == 0 || img_q.size() == 0) proto_err++;
      else begin
        void'(base_q.pop_front());
        void'(img_q.pop_front());
      end
      if (first_pop < 0) first_pop = cyc_cnt;
      last_pop = cyc_cnt;
      pops++;
    end
    if (wr === 1'b1) begin
      got_q.push_back(d);
      if (first_wr < 0) first_wr = cyc_cnt;
      last_wr = cyc_cnt;
    end
    if (dn === 1'b1) done_cnt++;
    set_inputs();
  endtask

  function automatic int absdiff(input int b, input int i);
    return (b > i) ? b - i : i - b;
  endfunction

  function automatic logic [DW-1:0] ref_pix(input int b, input int i, input int thr, input int md);
    int d;
    d = absdiff(b, i);
    if (md == 1) return DW'(d);
    if (md == 2) return (d > thr) ? DW'(d) : '0;
    return (d > thr) ? '1 : '0;
  endfunction

  task automatic fill_random(input int n);
    repeat (n) begin
      base_q.push_back(DW'($urandom_range(0, 255)));
      img_q.push_back(DW'($urandom_range(0, 255)));
    end
  endtask

  task automatic build_expected(input int thr, input int md);
    exp_q.delete();
    exp_fg = 0;
    for (int k = 0; k < TOTAL; k++) begin
      exp_q.push_back(ref_pix(int'(base_q[k]), int'(img_q[k]), thr, md));
      if (absdiff(int'(base_q[k]), int'(img_q[k])) > thr) exp_fg++;
    end
  endtask

  function automatic int mismatches();
    int m = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) m++;
    return m;
  endfunction

  function automatic logic [DW-1:0] got_at(input int k);
    return (k < got_q.size()) ? got_q[k] : 'x;
  endfunction

  task automatic start_frame(input int thr, input int md);
    got_q.delete();
    done_cnt = 0; pops = 0; proto_err = 0; busy_err = 0;
    first_pop = -1; last_pop = -1; first_wr = -1; last_wr = -1;
    set_inputs();
    threshold = DW'(thr); mode = 2'(md); start = 1'b1;
    cyc();
    start = 1'b0;
    threshold = DW'($urandom); mode = 2'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) cyc();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_empty_base = 1'b0; in_empty_img = 1'b0; out_full = 1'b0;
    #17;
    checks++;
    if ({done, busy, in_rd_en_base, in_rd_en_img, out_wr_en} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b required 00000", {done, busy, in_rd_en_base, in_rd_en_img, out_wr_en});
    end
    checks++;
    if (out_din !== '0) begin failures++; $display("FAIL reset_din: got %0h required 0", out_din); end
`ifdef SUBTRACT_FG_COUNT_EN
    checks++;
    if (fg_count !== '0) begin failures++; $display("FAIL reset_fg: got %0d required 0", fg_count); end
`endif
    #3 reset = 1'b1;
    base_q.push_back(8'd1); img_q.push_back(8'd2);
    set_inputs();
    repeat (2) cyc();
    checks++;
    if (busy !== 1'b0 || pops != 0) begin
      failures++; $display("FAIL idle_no_pop: busy %b pops %0d required 0 0", busy, pops);
    end
    base_q.delete(); img_q.delete();
  endtask

  task automatic test_mode0();
    full_mode = 0; img_gate = 0;
    repeat (4) base_q.push_back(8'd100);
    img_q.push_back(8'd100); img_q.push_back(8'd121); img_q.push_back(8'd79); img_q.push_back(8'd120);
    fill_random(TOTAL - 4);
    build_expected(20, 0);
    start_frame(20, 0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL m0_busy: got %b required 1", busy); end
    wait_done(400);
    checks++;
    if ({got_at(0), got_at(1), got_at(2), got_at(3)} !== 32'h00FFFF00) begin
      failures++; $display("FAIL m0_first4: got %h required 00ffff00", {got_at(0), got_at(1), got_at(2), got_at(3)});
    end
    checks++;
    if (got_q.size() != TOTAL || mismatches() != 0) begin
      failures++; $display("FAIL m0_frame: got %0d writes %0d mismatches required %0d 0", got_q.size(), mismatches(), TOTAL);
    end
    checks++;
    if (done_cnt != 1 || proto_err != 0 || busy_err != 0) begin
      failures++; $display("FAIL m0_ctrl: done %0d proto %0d busy %0d required 1 0 0", done_cnt, proto_err, busy_err);
    end
`ifdef SUBTRACT_FG_COUNT_EN
    checks++;
    if (fg_count !== CW'(exp_fg)) begin failures++; $display("FAIL m0_fg: got %0d required %0d", fg_count, exp_fg); end
`endif
  endtask

  task automatic test_mode1_latency();
    int thr;
    thr = $urandom_range(0, 255);
    base_q.push_back(8'd10);  img_q.push_back(8'd250);
    base_q.push_back(8'd250); img_q.push_back(8'd10);
    fill_random(TOTAL - 2);
    build_expected(thr, 1);
    start_frame(thr, 1);
    wait_done(400);
    checks++;
    if ({got_at(0), got_at(1)} !== {8'd240, 8'd240}) begin
      failures++; $display("FAIL m1_first2: got %0d %0d required 240 240", got_at(0), got_at(1));
    end
    checks++;
    if (first_wr - first_pop != 2) begin
      failures++; $display("FAIL m1_latency: got %0d required 2", first_wr - first_pop);
    end
    checks++;
    if (mismatches() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL m1_frame: mismatches %0d done %0d required 0 1", mismatches(), done_cnt);
    end
  endtask

  task automatic test_mode2();
    base_q.push_back(8'd100); img_q.push_back(8'd130);
    base_q.push_back(8'd100); img_q.push_back(8'd49);
    base_q.push_back(8'd250); img_q.push_back(8'd50);
    base_q.push_back(8'd0);   img_q.push_back(8'd50);
    fill_random(TOTAL - 4);
    build_expected(50, 2);
    start_frame(50, 2);
    wait_done(400);
    checks++;
    if ({got_at(0), got_at(1), got_at(2), got_at(3)} !== {8'd0, 8'd51, 8'd200, 8'd0}) begin
      failures++; $display("FAIL m2_first4: got %0d %0d %0d %0d required 0 51 200 0", got_at(0), got_at(1), got_at(2), got_at(3));
    end
    checks++;
    if (mismatches() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL m2_frame: mismatches %0d done %0d required 0 1", mismatches(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int md, thr;
    md = $urandom_range(0, 3); thr = $urandom_range(0, 255);
    fill_random(TOTAL);
    build_expected(thr, md);
    start_frame(thr, md);
    wait_done(400);
    checks++;
    if (last_pop - first_pop != TOTAL - 1 || last_wr - first_wr != TOTAL - 1) begin
      failures++; $display("FAIL b2b_span: pops %0d writes %0d required %0d", last_pop - first_pop, last_wr - first_wr, TOTAL - 1);
    end
    checks++;
    if (mismatches() != 0 || got_q.size() != TOTAL) begin
      failures++; $display("FAIL b2b_frame: mismatches %0d writes %0d required 0 %0d", mismatches(), got_q.size(), TOTAL);
    end
  endtask

  task automatic test_stress();
    for (int m = 0; m < 4; m++) begin
      int thr;
      full_mode = (m % 2 == 0) ? 1 : 2; img_gate = 1;
      thr = $urandom_range(0, 255);
      fill_random(TOTAL + 5);
      build_expected(thr, m);
      start_frame(thr, m);
      wait_done(1500);
      checks++;
      if (got_q.size() != TOTAL || mismatches() != 0) begin
        failures++; $display("FAIL stress_data m%0d: writes %0d mismatches %0d required %0d 0", m, got_q.size(), mismatches(), TOTAL);
      end
      checks++;
      if (done_cnt != 1 || proto_err != 0 || busy_err != 0) begin
        failures++; $display("FAIL stress_ctrl m%0d: done %0d proto %0d busy %0d required 1 0 0", m, done_cnt, proto_err, busy_err);
      end
      checks++;
      if (base_q.size() != 5 || img_q.size() != 5) begin
        failures++; $display("FAIL stress_left m%0d: base %0d img %0d required 5 5", m, base_q.size(), img_q.size());
      end
`ifdef SUBTRACT_FG_COUNT_EN
      checks++;
      if (fg_count !== CW'(exp_fg)) begin failures++; $display("FAIL stress_fg m%0d: got %0d required %0d", m, fg_count, exp_fg); end
`endif
      base_q.delete(); img_q.delete();
    end
    full_mode = 0; img_gate = 0;
  endtask

  task automatic test_reset_midframe();
    fill_random(TOTAL);
    start_frame(40, 0);
    for (int n = 0; n < 200 && pops < 10; n++) cyc();
    reset = 1'b0;
    #2;
    checks++;
    if ({done, busy, in_rd_en_base, in_rd_en_img, out_wr_en, out_din} !== '0) begin
      failures++; $display("FAIL midreset_out: got %b required 0", {done, busy, in_rd_en_base, in_rd_en_img, out_wr_en, out_din});
    end
    #10 reset = 1'b1;
    base_q.delete(); img_q.delete();
    done_cnt = 0;
    set_inputs();
    repeat (4) cyc();
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_idle: done %0d busy %b required 0 0", done_cnt, busy);
    end
    fill_random(TOTAL);
    build_expected(40, 0);
    start_frame(40, 0);
    wait_done(400);
    checks++;
    if (got_q.size() != TOTAL || mismatches() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL midreset_frame: writes %0d mismatches %0d done %0d required %0d 0 1", got_q.size(), mismatches(), done_cnt, TOTAL);
    end
  endtask

  task automatic test_start_ignored();
    fill_random(TOTAL);
    build_expected(10, 0);
    start_frame(10, 0);
    repeat (5) cyc();
    threshold = 8'd200; mode = 2'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(400);
    checks++;
    if (got_q.size() != TOTAL || mismatches() != 0 || done_cnt != 1) begin
      failures++; $display("FAIL start_ignored: writes %0d mismatches %0d done %0d required %0d 0 1", got_q.size(), mismatches(), done_cnt, TOTAL);
    end
`ifdef SUBTRACT_FG_COUNT_EN
    checks++;
    if (fg_count !== CW'(exp_fg)) begin failures++; $display("FAIL start_ignored_fg: got %0d required %0d", fg_count, exp_fg); end
`endif
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_latency();
    test_mode2();
    test_back_to_back();
    test_stress();
    test_reset_midframe();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/subtract_stream_core.md
Name: subtract_stream_core

Overview:
Streaming background-subtraction engine for the grayscale pipeline. It pops one base pixel and one image pixel per cycle from two first-word-fall-through (FWFT) input FIFOs and computes their absolute difference. It writes a mask/difference pixel to an output FIFO. This is a parametrised successor of the fixed 8-bit, single-mode subtract core, adding a runtime threshold, selectable output modes and frame-level start/done control.

Parameters:
DATA_WIDTH, 8, pixel bit width (applies to base, img and output).
WIDTH, 720, frame width in pixels.
HEIGHT, 540, frame height in pixels.
CNT_WIDTH, 20, pixel counter width; must satisfy 2^CNT_WIDTH >= WIDTH*HEIGHT.

Ports:
clock  in  1  core clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts a frame when IDLE
threshold  in  DATA_WIDTH  compare level, sampled on accepted start
mode  in  2  output mode, sampled on accepted start
done  out  1  one-cycle pulse after the last pixel of a frame is written
busy  out  1  high from accepted start until done
in_empty_base  in  1  base FIFO empty
in_rd_en_base  out  1  base FIFO pop
in_dout_base  in  DATA_WIDTH  base FIFO head data (FWFT)
in_empty_img  in  1  img FIFO empty
in_rd_en_img  out  1  img FIFO pop
in_dout_img  in  DATA_WIDTH  img FIFO head data (FWFT)
out_full  in  1  output FIFO full
out_wr_en  out  1  output FIFO push
out_din  out  DATA_WIDTH  output pixel

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pixel count=0; both pipeline valids=0; registered threshold/mode=0. All outputs are 0: done, busy, in_rd_en_*, out_wr_en, out_din.
- States:
  - IDLE: start=1 moves to RUN and latches threshold and mode.
  - RUN: consumes pixels.
  - DRAIN: entered when the consumed count reaches WIDTH*HEIGHT. Waits until both pipeline stages are empty.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in RUN, DRAIN and DONE.
- start outside IDLE is ignored. threshold and mode changes mid-frame have no effect.
- Pop rule: in RUN, when in_empty_base=0, in_empty_img=0 and stage 1 can advance, in_rd_en_base and in_rd_en_img are both driven to 1 in the same cycle. The two FIFOs are never popped independently.
- A stage can advance when it is invalid, or when the stage after it advances.
- Stage 1 registers diff = |base - img| at DATA_WIDTH bits. Computation is unsigned, with no overflow possible.
- Stage 2 registers the result according to the latched mode:
  - mode 0: binary mask; all ones if diff > threshold, else 0.
  - mode 1: raw diff.
  - mode 2: gated diff; diff if diff > threshold, else 0.
  - mode 3: same as mode 0.
- out_wr_en = stage-2 valid AND out_full=0, driven combinationally from registered valid and the input. out_din holds the stage-2 data.
- Latency: a pop in cycle N produces out_wr_en no earlier than N+2. Throughput is 1 pixel/cycle with no bubbles while the inputs are non-empty and the output is not full.
- out_full=1: stage 2 holds its data, and stage 1 holds if it is valid. Pops stop once stage 1 is full and blocked. No data loss, no duplication.
- Pixel count increments on each pop. No pop occurs once the count equals WIDTH*HEIGHT, so extra FIFO data stays for the next frame. The count clears on an accepted start.
- Equality diff == threshold counts as background (0).
- Reset mid-frame aborts immediately. In-flight pixels are discarded and no done is issued.

Optional Feature:
SUBTRACT_FG_COUNT_EN
- Defined: adds output port fg_count [CNT_WIDTH] (reset 0).
  - Cleared on accepted start.
  - Incremented once per stage-2 result with diff > threshold, counted when it is written.
  - Stable and valid from the done pulse until the next accepted start.
- Not defined: the port and its counter do not exist, and core behaviour is identical.

Test Plan:
- Mode 0, threshold=20, base=100, img values 100,121,79,120: out_din 0x00,0xFF,0xFF,0x00; done pulses once after 4 writes (WIDTH=4, HEIGHT=1).
- Mode 1, base=10, img=250 and base=250, img=10: both outputs 240; out_wr_en first asserts 2 cycles after the first pop.
- Mode 2, threshold=50, diffs 30,51,200: outputs 0,51,200.
- Full frame 720x540 with out_full toggled every 3rd cycle and in_empty_img pseudo-random: exactly 388800 writes, no loss or duplication versus the reference model; pops are always paired; done pulses once; busy drops in the cycle after done.
- Reset asserted low mid-RUN after 100 pixels: all outputs 0 immediately; a subsequent start processes a full fresh frame correctly.
- start pulsed during RUN with a new threshold: ignored, and the frame completes with the original threshold. With SUBTRACT_FG_COUNT_EN, fg_count equals the model foreground count at done.
